// File: rtl/ifu_fetch.sv
`timescale 1ns/1ps
// ifu_fetch: PC register and instruction-fetch sequencer for the MIPS core.
// Fetches the word at pc, presents {pc, instr} to decode, then reloads pc from npc.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        instr_ready,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        err,
  output logic [31:0] err_pc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Window bounds carry an extra bit so a window ending at 2^32 does not wrap.
  localparam logic [32:0] WIN_LO = {1'b0, IMEM_BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(IMEM_WORDS) << 2);
  localparam bit RESET_PC_OK = (RESET_PC[1:0] == 2'b00) &&
                               ({1'b0, RESET_PC} >= WIN_LO) &&
                               ({1'b0, RESET_PC} <  WIN_HI);

  if (!RESET_PC_OK) begin : g_reset_pc_check
    $error("ifu_fetch: RESET_PC is not a legal fetch address");
  end

  function automatic logic pc_legal(input logic [31:0] addr);
    logic [32:0] addr_x;
    addr_x = {1'b0, addr};
    return (addr[1:0] == 2'b00) && (addr_x >= WIN_LO) && (addr_x < WIN_HI);
  endfunction

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] err_pc_r;
  logic [31:0] fetch_cnt_r;
  logic        npc_ok_s;

  assign npc_ok_s = pc_legal(npc);

  // Fetch sequencer: owns pc, captured instruction, fault capture and accept counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_BOOT;
      pc_r        <= RESET_PC;
      instr_r     <= 32'h0000_0000;
      err_pc_r    <= 32'h0000_0000;
      fetch_cnt_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_gnt) begin
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            instr_r <= imem_rdata;
            state_r <= ST_VALID;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_VALID: begin
          if (instr_ready) begin
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
            if (npc_ok_s) begin
              pc_r    <= npc;
              state_r <= ST_FETCH;
            end else begin
              err_pc_r <= npc;
              state_r  <= ST_ERR;
            end
          end else begin
            state_r <= ST_VALID;
          end
        end
        ST_ERR: begin
          state_r <= ST_ERR;
        end
        default: begin
          state_r <= ST_ERR;
        end
      endcase
    end
  end

  assign imem_req    = (state_r == ST_FETCH);
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign instr_valid = (state_r == ST_VALID);
  assign err         = (state_r == ST_ERR);
  assign err_pc      = err_pc_r;
  assign fetch_cnt   = fetch_cnt_r;

endmodule

// File: tb/tb_ifu_fetch.sv
`timescale 1ns/1ps
// Directed bench for ifu_fetch: a hand-driven instruction memory pushes the
// expected {pc, instr} into a scoreboard that is popped when decode accepts.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] npc = 32'h0000_0000;
  logic        instr_ready = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        err;
  logic [31:0] err_pc;
  logic [31:0] fetch_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .npc         (npc),
    .instr_ready (instr_ready),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .err         (err),
    .err_pc      (err_pc),
    .fetch_cnt   (fetch_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},     pc,          32'h0000_3000);
    chk({tag, "_instr"},  instr,       32'h0000_0000);
    chk({tag, "_valid"},  instr_valid, 32'd0);
    chk({tag, "_req"},    imem_req,    32'd0);
    chk({tag, "_err"},    err,         32'd0);
    chk({tag, "_err_pc"}, err_pc,      32'h0000_0000);
    chk({tag, "_cnt"},    fetch_cnt,   32'd0);
  endtask

  // Serve one fetch: hold off gnt, then hold off rvalid, then return data.
  task automatic do_fetch(input logic [31:0] addr, input int gnt_dly,
                          input int rv_dly, input logic [31:0] data);
    chk("fetch_req", imem_req, 32'd1);
    chk("fetch_addr", imem_addr, addr);
    for (int i = 0; i < gnt_dly; i++) begin
      step();
      chk("req_hold", imem_req, 32'd1);
      chk("addr_hold", imem_addr, addr);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("wait_req", imem_req, 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      step();
      chk("wait_no_valid", instr_valid, 32'd0);
    end
    imem_rdata  = data;
    imem_rvalid = 1'b1;
    sb_q.push_back('{pc: addr, instr: data});
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
  endtask

  // Check the presented instruction against the scoreboard, stall, then accept.
  task automatic accept(input logic [31:0] next_pc, input int hold);
    exp_t e;
    chk("valid", instr_valid, 32'd1);
    n_total++;
    assert (sb_q.size() > 0) begin
      n_pass++;
      e = sb_q.pop_front();
    end else begin
      n_fail++;
      $error("FAIL sb_empty: observed=0 entries expected=1 entry");
      e = '0;
    end
    chk("sb_pc", pc, e.pc);
    chk("sb_instr", instr, e.instr);
    npc = $urandom;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("stall_valid", instr_valid, 32'd1);
      chk("stall_pc", pc, e.pc);
      chk("stall_instr", instr, e.instr);
    end
    npc         = next_pc;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    npc         = $urandom;
  endtask

  initial begin
    // Reset values
    reset = 1'b0;
    repeat (2) step();
    chk_reset("rst0");

    // Back-to-back best case
    reset = 1'b1;
    step();
    do_fetch(32'h0000_3000, 0, 0, 32'h2008_0005);
    accept(32'h0000_3004, 0);
    chk("cnt1", fetch_cnt, 32'd1);
    chk("next_req", imem_req, 32'd1);
    chk("next_addr", imem_addr, 32'h0000_3004);

    // Slow memory and stalled decode; jump to the last legal word
    do_fetch(32'h0000_3004, 3, 5, 32'h8C01_0004);
    accept(32'h0000_3FFC, 4);
    chk("cnt2", fetch_cnt, 32'd2);
    do_fetch(32'h0000_3FFC, 1, 2, 32'h1000_FFFF);

    // Misaligned npc faults
    accept(32'h0000_3002, 0);
    chk("mis_err", err, 32'd1);
    chk("mis_err_pc", err_pc, 32'h0000_3002);
    chk("mis_pc", pc, 32'h0000_3FFC);
    chk("mis_valid", instr_valid, 32'd0);
    chk("mis_req", imem_req, 32'd0);
    chk("mis_cnt", fetch_cnt, 32'd3);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    instr_ready = 1'b1;
    repeat (3) step();
    chk("err_sticky", err, 32'd1);
    chk("err_req", imem_req, 32'd0);
    chk("err_valid", instr_valid, 32'd0);
    chk("err_cnt", fetch_cnt, 32'd3);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;

    // Out-of-range npc faults (one past the window)
    reset = 1'b0;
    step();
    chk_reset("rst1");
    reset = 1'b1;
    step();
    do_fetch(32'h0000_3000, 0, 1, 32'h2402_000A);
    accept(32'h0000_4000, 0);
    chk("oor_err", err, 32'd1);
    chk("oor_err_pc", err_pc, 32'h0000_4000);
    chk("oor_pc", pc, 32'h0000_3000);
    chk("oor_cnt", fetch_cnt, 32'd1);

    // Reset mid-WAIT, stale rvalid during BOOT and FETCH is dropped
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("midwait_req", imem_req, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset("rst_wait");
    imem_rdata  = 32'hDEAD_BEEF;
    imem_rvalid = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("stale_instr", instr, 32'h0000_0000);
    chk("stale_valid", instr_valid, 32'd0);
    chk("stale_req", imem_req, 32'd1);
    chk("stale_addr", imem_addr, 32'h0000_3000);
    step();
    chk("stale_fetch_instr", instr, 32'h0000_0000);
    chk("stale_fetch_valid", instr_valid, 32'd0);
    imem_rvalid = 1'b0;

    // Self-loop refetches the same word
    for (int i = 0; i < 5; i++) begin
      do_fetch(32'h0000_3000, i % 2, (i + 1) % 3, 32'h0800_0C00 | 32'(i));
      accept(32'h0000_3000, i % 2);
    end
    chk("loop_cnt", fetch_cnt, 32'd5);
    chk("loop_err", err, 32'd0);
    chk("loop_req", imem_req, 32'd1);
    chk("loop_addr", imem_addr, 32'h0000_3000);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- PC register and instruction-fetch sequencer for the MIPS core. It sits directly upstream of the next-PC logic.
- Holds `pc`, fetches the word at `pc` from a variable-latency instruction memory, and presents `{pc, instr}` to decode with a valid/ready handshake.
- When an instruction is accepted, `pc` is loaded from the `npc` value computed downstream from the current `pc`/`instr`.
- Flags and freezes on misaligned or out-of-range next-PC values.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_WORDS, 1024, legal window is IMEM_BASE .. IMEM_BASE+4*IMEM_WORDS-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- npc  input  32  next PC for the instruction currently presented; sampled only on accept.
- instr_ready  input  1  core consumes the presented instruction this cycle.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; never in the same cycle as its gnt.
- imem_rdata  input  32  read data.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, word-aligned.
- pc  output  32  address of the presented instruction.
- instr  output  32  fetched instruction word.
- instr_valid  output  1  `pc`/`instr` valid for decode.
- err  output  1  fetch fault, sticky until reset.
- err_pc  output  32  offending `npc` value.
- fetch_cnt  output  32  count of accepted instructions.

Behaviour:
- Reset (`reset`=0, asynchronous), output values:
  - state=BOOT, `pc`=RESET_PC, `instr`=0.
  - `instr_valid`=0, `imem_req`=0, `err`=0, `err_pc`=0, `fetch_cnt`=0.
  - RESET_PC must be legal; a compile-time check flags violations.
- States: BOOT, FETCH, WAIT, VALID, ERR. All outputs are decoded from registered state.
- BOOT: `imem_req`=0. Go to FETCH on the next edge after reset deasserts.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`; `req` and `addr` hold stable until `imem_gnt`.
  - On `imem_gnt` go to WAIT.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`: capture `instr`<=`imem_rdata` and go to VALID.
  - Unbounded latency; no timeout.
- VALID:
  - `instr_valid`=1; `pc`/`instr` hold stable while `instr_ready`=0.
  - On `instr_ready`:
    - `fetch_cnt`++ (wraps 32'hFFFF_FFFF->0).
    - If `npc[1:0]`!=0 or `npc` is outside the legal window: `err_pc`<=`npc`, go to ERR; `pc` is unchanged.
    - Otherwise `pc`<=`npc`, go to FETCH. The next request goes out one cycle after accept, so there is a 1-cycle bubble minimum.
- ERR:
  - `err`=1, `instr_valid`=0, `imem_req`=0.
  - Ignores all inputs; exit only by reset.
- `imem_rvalid` outside WAIT is ignored, e.g. a stale response after a reset mid-transaction.
- `imem_gnt` outside FETCH is ignored.
- Throughput: best case 3 cycles per instruction (FETCH with gnt, WAIT with rvalid next cycle, VALID with ready).
- `npc` is not sampled outside the VALID accept cycle. `npc`==`pc` (self-loop) is legal and refetches the same word.
- Legal-window arithmetic is done in 33 bits so IMEM_BASE+4*IMEM_WORDS near 2^32 does not wrap.
- Reset asserted in any state, including mid-WAIT or ERR, returns immediately to the reset values.

Test Plan:
- Reset release, `gnt`=1 immediately, `rvalid` next cycle with 32'h2008_0005, `ready`=1, `npc`=32'h3004 -> first `imem_addr`=32'h3000 two edges after reset; `instr_valid` with `pc`=3000 and `instr`=20080005; next `imem_addr`=32'h3004; `fetch_cnt`=1.
- `gnt` delayed 3 cycles, `rvalid` delayed 5 cycles -> `imem_req`/`imem_addr` steady 3 cycles; `instr_valid` only after `rvalid`; `ready` held 0 for 4 cycles keeps `pc`/`instr` unchanged.
- Accept with `npc`=32'h3002 -> `err`=1, `err_pc`=32'h3002, `pc` stays at old value, `imem_req` stays 0 thereafter; `fetch_cnt` incremented.
- Accept with `npc`=32'h4000 (IMEM_WORDS=1024) -> `err`=1; `npc`=32'h3FFC -> legal fetch at 3FFC.
- Reset pulsed during WAIT, then `rvalid` arrives during BOOT -> response ignored; `pc`=3000, `instr_valid`=0, fresh FETCH issued.
- Jump sequence `npc`=3000 repeated 5 times -> 5 fetches of address 3000, `fetch_cnt`=5, no `err`.
